aes_inv_round_ctrl: RTL and testbench
=====================================

Name: aes_inv_round_ctrl

Overview:
- Iterative AES-128 decryption engine controller: owns the 128-bit state register, the round counter and the sequencing FSM.
- Applies one inverse round per clock using the team's existing combinational InvShiftRows, InvSubBytes, InvMixColumns and AddRoundKey blocks.
- Round keys are fetched from an external expanded-key store by index.
- Sits between the decryption front-end (valid/ready ciphertext source) and the plaintext consumer.

Parameters:
- NR, 10, number of rounds (AES-128); the round index width is 4 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  ciphertext block offered.
- inReady  out  1  controller can accept a block.
- cipherIn  in  128  ciphertext, byte 0 at bits [0:7] (big-endian [0:127] ordering, matching the datapath).
- keyIdx  out  4  round-key index requested from the key store.
- roundKey  in  128  key for keyIdx; combinational, valid in the same cycle.
- outValid  out  1  plaintext available.
- outReady  in  1  consumer accepts plaintext.
- plainOut  out  128  plaintext, same byte ordering.
- busy  out  1  high in ROUND, FINAL and DONE.

Behaviour:
- Reset (async, active-high): FSM=IDLE, state register=0, round=0.
  - Outputs during reset: inReady=1, outValid=0, busy=0, plainOut=0, keyIdx=NR.
- State IDLE:
  - inReady=1, keyIdx=NR.
  - On inValid&&inReady at a rising edge: state <= cipherIn ^ roundKey; round <= NR-1; go to ROUND.
  - inValid without an edge: no change.
- State ROUND:
  - inReady=0, keyIdx=round.
  - Each edge: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ roundKey).
  - If round==1: go to FINAL. Otherwise round <= round-1.
- State FINAL:
  - keyIdx=0.
  - At the edge: state <= InvSubBytes(InvShiftRows(state)) ^ roundKey. No InvMixColumns. Go to DONE.
- State DONE:
  - outValid=1 and plainOut=state.
  - Both stay stable until outReady is sampled high.
  - On outValid&&outReady: go to IDLE and clear outValid. plainOut holds its last value.
- Latency:
  - Accept edge E0; ROUND edges E1..E(NR-1); FINAL edge ENR.
  - outValid rises after edge ENR, i.e. 10 edges after acceptance for NR=10.
- Throughput: one block per NR+2 cycles when outReady is held high. There is no overlap: inReady=0 from acceptance until the DONE handshake completes.
- No same-cycle output-to-input pass-through: a DONE handshake and a new acceptance occur on separate edges.
- Back-pressure: outReady low holds DONE indefinitely. inValid is ignored outside IDLE and the state is untouched.
- keyIdx is a pure function of FSM and round (registered decode is permitted only if its value is identical in every cycle). It never exceeds NR and never underflows below 0.
- Reset asserted mid-operation: immediate return to the reset values. The in-flight block is discarded and no outValid pulse is produced.
- The arithmetic is GF(2^8) via the instantiated blocks. XOR is bitwise over 128 bits. round is a 4-bit down-counter with no wrap.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: expanded key for 000102030405060708090a0b0c0d0e0f; cipherIn=69c4e0d86a7b0430d8cdb78070b4c55a; outReady=1.
  - Required: plainOut=00112233445566778899aabbccddeeff with outValid exactly 10 edges after acceptance.
  - Required keyIdx sequence: 10,9,8,…,1,0.
- Back-to-back:
  - Stimulus: two blocks with inValid held high, the second being FIPS-197 B ciphertext 3925841d02dc09fbdc118597196a0b32 with key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: outputs in order, correct plaintext 3243f6a8885a308d313198a2e0370734, and the second acceptance occurs at least 12 cycles after the first.
- Back-pressure:
  - Stimulus: outReady=0 for 20 cycles after DONE is reached.
  - Required: outValid and plainOut are stable, inReady=0, and inValid pulses are ignored. Releasing outReady gives a single handshake, then IDLE.
- Reset mid-round:
  - Stimulus: assert reset during round index 5.
  - Required: asynchronously outValid=0, inReady=1, keyIdx=10, busy=0. A fresh C.1 decryption afterwards is correct.
- Idle hygiene:
  - Stimulus: inValid=0 for 50 cycles.
  - Required: busy=0, keyIdx=10, state register unchanged.

Source files
------------

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys fetched by index.
// Latency: plaintext valid 10 edges after acceptance (NR edges); one block per NR+2 cycles.
// Backpressure: DONE holds until outReady; inReady is low from acceptance until the DONE handshake.
module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] cipherIn,
    output logic [3:0]   keyIdx,
    input  logic [127:0] roundKey,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] plainOut,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] NR_IDX  = 4'(NR);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    // Byte 0 is the most significant byte; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [1:0]   fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] plain_q, plain_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] sub_key;

    assign sub_key = inv_shift_sub(state_q) ^ roundKey;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        round_d = round_q;
        plain_d = plain_q;
        case (fsm_q)
            S_IDLE: begin
                if (inValid) begin
                    state_d = cipherIn ^ roundKey;
                    round_d = NR_IDX - 4'd1;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = inv_mix(sub_key);
                if (round_q == 4'd1) begin
                    fsm_d = S_FINAL;
                end else if (round_q != 4'd0) begin
                    round_d = round_q - 4'd1;
                end
            end
            S_FINAL: begin
                state_d = sub_key;
                plain_d = sub_key;
                fsm_d   = S_DONE;
            end
            default: begin
                if (outReady) fsm_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        keyIdx = NR_IDX;
        case (fsm_q)
            S_ROUND: keyIdx = round_q;
            S_FINAL: keyIdx = 4'd0;
            default: keyIdx = NR_IDX;
        endcase
    end

    assign inReady  = (fsm_q == S_IDLE);
    assign outValid = (fsm_q == S_DONE);
    assign busy     = (fsm_q != S_IDLE);
    assign plainOut = plain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            plain_q <= '0;
            round_q <= 4'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            plain_q <= plain_d;
            round_q <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: FIPS-197 vectors, back-to-back, back-pressure, mid-round reset, idle.
module tb_aes_inv_round_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         inValid = 1'b0;
    logic         outReady = 1'b1;
    logic [127:0] cipherIn = '0;
    logic [127:0] roundKey;
    logic [127:0] plainOut;
    logic         inReady, outValid, busy;
    logic [3:0]   keyIdx;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int key_sel = 0;

    logic [127:0] rk [0:2][0:10];
    int           acc_q[$];
    logic [127:0] out_q[$];

    typedef struct {
        logic [127:0] ct;
        int           ks;
        logic [127:0] pt;
        string        name;
    } vec_t;
    vec_t tbl [0:2];

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    aes_inv_round_ctrl #(.NR(10)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .cipherIn(cipherIn), .keyIdx(keyIdx), .roundKey(roundKey),
        .outValid(outValid), .outReady(outReady), .plainOut(plainOut), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        if (!reset && inValid && inReady) acc_q.push_back(cyc);
        if (!reset && outValid && outReady) out_q.push_back(plainOut);
    end

    assign roundKey = (keyIdx <= 4'd10) ? rk[key_sel][keyIdx] : 128'h0;

    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = tb_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_rotl(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] y = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (x != 8'h00 && tb_mul(x, 8'(c)) == 8'h01) y = 8'(c);
        end
        return y ^ tb_rotl(y, 1) ^ tb_rotl(y, 2) ^ tb_rotl(y, 3) ^ tb_rotl(y, 4) ^ 8'h63;
    endfunction

    task automatic expand(input int s, input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])} ^ {rc, 24'h0};
                rc = tb_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] ct, input int ks, input logic [127:0] pt, input string name);
        int edges = 0;
        key_sel  = ks;
        cipherIn = ct;
        outReady = 1'b1;
        inValid  = 1'b1;
        chk({name, " inReady idle"}, 128'(inReady), 128'd1);
        chk({name, " keyIdx idle"}, 128'(keyIdx), 128'd10);
        tick();
        inValid = 1'b0;
        while (!outValid && edges < 30) begin
            chk({name, " keyIdx seq"}, 128'(keyIdx), (edges < 9) ? 128'(9 - edges) : 128'd0);
            chk({name, " busy"}, 128'(busy), 128'd1);
            chk({name, " inReady busy"}, 128'(inReady), 128'd0);
            tick();
            edges++;
        end
        chk({name, " latency"}, 128'(edges), 128'd10);
        chk({name, " plain"}, plainOut, pt);
        tick();
        chk({name, " outValid clear"}, 128'(outValid), 128'd0);
        chk({name, " back to idle"}, 128'(inReady), 128'd1);
        chk({name, " plain hold"}, plainOut, pt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        tbl[0] = '{C1_CT, 0, C1_PT, "fips_c1"};
        tbl[1] = '{B_CT, 1, B_PT, "fips_b"};
        tbl[2] = '{128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 128'h0, "zero_key"};
        expand(0, 128'h000102030405060708090a0b0c0d0e0f);
        expand(1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        expand(2, 128'h0);

        #1 reset = 1'b1;
        #1;
        chk("reset inReady", 128'(inReady), 128'd1);
        chk("reset outValid", 128'(outValid), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset keyIdx", 128'(keyIdx), 128'd10);
        chk("reset plainOut", plainOut, 128'h0);
        #20 reset = 1'b0;
        tick();

        for (int v = 0; v < 3; v++) run_block(tbl[v].ct, tbl[v].ks, tbl[v].pt, tbl[v].name);

        // Back-to-back with inValid held high; key store switches once block 1 is DONE.
        acc_q.delete();
        out_q.delete();
        key_sel = 0; cipherIn = C1_CT; outReady = 1'b1; inValid = 1'b1;
        n = 0;
        while (!outValid && n < 40) begin tick(); n++; end
        key_sel = 1; cipherIn = B_CT;
        n = 0;
        while (acc_q.size() < 2 && n < 40) begin tick(); n++; end
        inValid = 1'b0;
        n = 0;
        while (out_q.size() < 2 && n < 40) begin tick(); n++; end
        tick(); tick();
        chk("b2b accept count", 128'(acc_q.size()), 128'd2);
        chk("b2b output count", 128'(out_q.size()), 128'd2);
        if (acc_q.size() >= 2) chk("b2b accept gap", 128'(acc_q[1] - acc_q[0]), 128'd12);
        if (out_q.size() >= 2) begin
            chk("b2b first plain", out_q[0], C1_PT);
            chk("b2b second plain", out_q[1], B_PT);
        end

        // Back-pressure: DONE held for 20 cycles while inValid pulses.
        acc_q.delete();
        out_q.delete();
        key_sel = 0; cipherIn = C1_CT; outReady = 1'b0; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 30) begin tick(); n++; end
        chk("bp reached done", 128'(outValid), 128'd1);
        for (int i = 0; i < 20; i++) begin
            inValid  = i[0];
            cipherIn = B_CT;
            tick();
            chk("bp outValid", 128'(outValid), 128'd1);
            chk("bp plain stable", plainOut, C1_PT);
            chk("bp inReady", 128'(inReady), 128'd0);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        tick();
        chk("bp release outValid", 128'(outValid), 128'd0);
        chk("bp release idle", 128'(inReady), 128'd1);
        tick(); tick();
        chk("bp single handshake", 128'(out_q.size()), 128'd1);
        chk("bp pulses ignored", 128'(acc_q.size()), 128'd1);
        chk("bp busy after", 128'(busy), 128'd0);

        // Reset while round index 5 is being applied.
        out_q.delete();
        key_sel = 0; cipherIn = C1_CT; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        n = 0;
        while (keyIdx != 4'd5 && n < 20) begin tick(); n++; end
        chk("rst reached round5", 128'(keyIdx), 128'd5);
        #2 reset = 1'b1;
        #1;
        chk("rst async outValid", 128'(outValid), 128'd0);
        chk("rst async inReady", 128'(inReady), 128'd1);
        chk("rst async keyIdx", 128'(keyIdx), 128'd10);
        chk("rst async busy", 128'(busy), 128'd0);
        chk("rst async plainOut", plainOut, 128'h0);
        tick(); tick();
        #3 reset = 1'b0;
        tick(); tick();
        chk("rst no out pulse", 128'(out_q.size()), 128'd0);
        run_block(C1_CT, 0, C1_PT, "after_reset");

        // Idle hygiene: 50 cycles with inValid low and noise on cipherIn.
        for (int i = 0; i < 50; i++) begin
            inValid = 1'b0;
            cipherIn = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("idle busy", 128'(busy), 128'd0);
            chk("idle keyIdx", 128'(keyIdx), 128'd10);
            chk("idle inReady", 128'(inReady), 128'd1);
            chk("idle plain", plainOut, C1_PT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
